// File: rtl/popcount_unary_expander.sv
// popcount_unary_expander
//   Turns a count into a FRAME_LEN-beat serial bitstream carrying exactly that many
//   ones (counts above FRAME_LEN are clamped). Two patterns:
//     thermometer (i_in_mode=0): ones occupy the first cnt beats;
//     distributed (i_in_mode=1): an accumulator spreads the ones evenly over the frame.
//   The serial outputs are registered. A new request may be accepted in the same cycle
//   as the last beat of the current frame, so frames can stream with no bubble.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   count/mode presented
//   o_in_ready   a new frame request can be accepted
//   i_in_count   number of ones to emit (clamped to FRAME_LEN)
//   i_in_mode    0 = thermometer, 1 = distributed
//   o_out_valid  o_out_bit is valid
//   i_out_ready  downstream accepts the current beat
//   o_out_bit    current stream bit
//   o_out_last   marks beat FRAME_LEN-1 of the frame
//   o_busy       a frame is in progress
module popcount_unary_expander #(
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned FRAME_LEN = 15
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [CNT_W-1:0] i_in_count,
    input  logic             i_in_mode,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_out_bit,
    output logic             o_out_last,
    output logic             o_busy
);

    localparam int unsigned BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned CNTV_W    = $clog2(FRAME_LEN + 1);
    localparam int unsigned ACC_W     = (FRAME_LEN > 1) ? $clog2(2 * FRAME_LEN) : 1;
    localparam int unsigned LAST_BEAT = FRAME_LEN - 1;

    typedef enum logic {
        StIdle,
        StSend
    } state_t;

    state_t              r_state, w_state_d;
    logic [CNTV_W-1:0]   r_cnt, w_cnt_d;
    logic                r_mode, w_mode_d;
    logic [BEAT_W-1:0]   r_beat, w_beat_d;
    logic [ACC_W-1:0]    r_acc, w_acc_d;
    logic                r_out_bit, w_out_bit_d;
    logic                r_out_last, w_out_last_d;

    logic [31:0]         w_cnt_clamp32;
    logic [CNTV_W-1:0]   w_cnt_clamp;
    logic                w_last_xfer;
    logic                w_accept;
    logic [CNTV_W-1:0]   w_step_cnt;
    logic [ACC_W-1:0]    w_step_acc;
    logic                w_step_mode;
    logic [31:0]         w_step_beat32;
    logic [31:0]         w_sum32;
    logic                w_dist_hit;
    logic [31:0]         w_acc_next32;
    logic                w_step_bit;
    logic                w_step_last;

    // Handshake decode
    always_comb begin
        w_cnt_clamp32 = (32'(i_in_count) > FRAME_LEN) ? FRAME_LEN : 32'(i_in_count);
        w_cnt_clamp   = w_cnt_clamp32[CNTV_W-1:0];
        w_last_xfer   = (r_state == StSend) && i_out_ready && r_out_last;
        // The last-beat transfer frees the block in the same cycle: no bubble between frames.
        o_in_ready    = (r_state == StIdle) || w_last_xfer;
        w_accept      = i_in_valid && o_in_ready;
    end

    // One step of the bit generator. On acceptance it computes beat 0 of the new frame
    // from a fresh (zero) accumulator; otherwise it computes the beat after r_beat.
    always_comb begin
        w_step_cnt    = w_accept ? w_cnt_clamp : r_cnt;
        w_step_acc    = w_accept ? '0 : r_acc;
        w_step_mode   = w_accept ? i_in_mode : r_mode;
        w_step_beat32 = w_accept ? 32'd0 : (32'(r_beat) + 32'd1);

        w_sum32       = 32'(w_step_acc) + 32'(w_step_cnt);
        w_dist_hit    = (w_sum32 >= FRAME_LEN);
        w_acc_next32  = w_dist_hit ? (w_sum32 - FRAME_LEN) : w_sum32;

        w_step_bit    = w_step_mode ? w_dist_hit : (w_step_beat32 < 32'(w_step_cnt));
        w_step_last   = (w_step_beat32 == LAST_BEAT);
    end

    // Next-state
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_mode_d     = r_mode;
        w_beat_d     = r_beat;
        w_acc_d      = r_acc;
        w_out_bit_d  = r_out_bit;
        w_out_last_d = r_out_last;

        if (w_accept) begin
            w_state_d    = StSend;
            w_cnt_d      = w_cnt_clamp;
            w_mode_d     = i_in_mode;
            w_beat_d     = '0;
            w_acc_d      = w_acc_next32[ACC_W-1:0];
            w_out_bit_d  = w_step_bit;
            w_out_last_d = w_step_last;
        end else if ((r_state == StSend) && i_out_ready) begin
            if (r_out_last) begin
                w_state_d    = StIdle;
                w_beat_d     = '0;
                w_acc_d      = '0;
                w_out_bit_d  = 1'b0;
                w_out_last_d = 1'b0;
            end else begin
                w_beat_d     = w_step_beat32[BEAT_W-1:0];
                w_acc_d      = w_acc_next32[ACC_W-1:0];
                w_out_bit_d  = w_step_bit;
                w_out_last_d = w_step_last;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_beat     <= '0;
            r_acc      <= '0;
            r_out_bit  <= 1'b0;
            r_out_last <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_mode     <= w_mode_d;
            r_beat     <= w_beat_d;
            r_acc      <= w_acc_d;
            r_out_bit  <= w_out_bit_d;
            r_out_last <= w_out_last_d;
        end
    end

    always_comb begin
        o_out_valid = (r_state == StSend);
        o_busy      = (r_state == StSend);
        o_out_bit   = r_out_bit;
        o_out_last  = r_out_last;
    end

endmodule
